// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master transfer sequencer
package spi_pkg;

    localparam int SPI_BAUD_W      = 12;
    localparam int SPI_FRAME_BITS  = 8;
    localparam int SPI_FRAME_EDGES = 2 * SPI_FRAME_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_baud_gen.sv
// rtl/spi_baud_gen.sv - SCLK half-period counter with terminal-count strobe
module spi_baud_gen
    import spi_pkg::*;
#(
    parameter int BAUD_W = SPI_BAUD_W
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       en,
    input  logic [2:0] sppr,
    input  logic [2:0] spr,
    output logic       tc
);

    logic [BAUD_W-1:0] half;
    logic [BAUD_W-1:0] cnt_q;

    // Half-period H = (sppr+1) * 2^spr, i.e. half of the divisor (sppr+1) * 2^(spr+1).
    assign half = BAUD_W'({1'b0, sppr} + 4'd1) << spr;
    assign tc   = en && (cnt_q == half - BAUD_W'(1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (!en || tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - SPI frame sequencer: SS, SCLK and shift strobes; SPI_MODF_EN enables mode-fault abort
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int BAUD_W = SPI_BAUD_W
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       spe_i,
    input  logic       cpol_i,
    input  logic       cpha_i,
    input  logic [2:0] sppr_i,
    input  logic [2:0] spr_i,
    input  logic       send_req_i,
    input  logic       ss_in_i,
    output logic       ss_o,
    output logic       sclk_o,
    output logic       send_data_o,
    output logic       receive_data_o,
    output logic       mosi_send_sclk_o,
    output logic       mosi_send_sclk0_o,
    output logic       miso_receive_sclk_o,
    output logic       miso_receive_sclk0_o,
    output logic       tip_o,
    output logic       spif_o,
    output logic       modf_o
);

    spi_state_e state_q, state_d;
    logic       cpol_q, cpha_q;
    logic [2:0] sppr_q, spr_q;
    logic       sclk_q;
    logic [3:0] edge_cnt_q;
    logic       sends_done_q;
    logic       rx_rise_q, rx_fall_q;
    logic       tc, fault, stay, tx_fire;
    logic       unused_ok;

`ifdef SPI_MODF_EN
    logic modf_q;

    assign fault  = spe_i && !ss_in_i && (state_q != IDLE);
    assign modf_o = modf_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            modf_q <= 1'b0;
        end else if (!spe_i) begin
            modf_q <= 1'b0;
        end else if (fault) begin
            modf_q <= 1'b1;
        end
    end

    assign unused_ok = &{1'b0, cpha_q};
`else
    assign fault     = 1'b0;
    assign modf_o    = 1'b0;
    assign unused_ok = &{1'b0, cpha_q, ss_in_i};
`endif

    spi_baud_gen #(.BAUD_W(BAUD_W)) u_baud (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .en      (state_q == XFER),
        .sppr    (sppr_q),
        .spr     (spr_q),
        .tc      (tc)
    );

    assign stay    = spe_i && !fault;
    assign tx_fire = (state_q == XFER) && tc && !sends_done_q && stay;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (send_req_i && spe_i) state_d = START;
            START:   state_d = XFER;
            XFER:    if ((rx_rise_q || rx_fall_q) && sends_done_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!stay) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            sppr_q       <= '0;
            spr_q        <= '0;
            sclk_q       <= 1'b0;
            edge_cnt_q   <= '0;
            sends_done_q <= 1'b0;
            rx_rise_q    <= 1'b0;
            rx_fall_q    <= 1'b0;
        end else begin
            rx_rise_q <= tx_fire && !sclk_q;
            rx_fall_q <= tx_fire && sclk_q;
            if (state_q == START) begin
                cpol_q       <= cpol_i;
                cpha_q       <= cpha_i;
                sppr_q       <= sppr_i;
                spr_q        <= spr_i;
                edge_cnt_q   <= '0;
                sends_done_q <= 1'b0;
            end else if (tx_fire) begin
                edge_cnt_q <= edge_cnt_q + 4'd1;
                if (edge_cnt_q == 4'(SPI_FRAME_EDGES - 1)) begin
                    sends_done_q <= 1'b1;
                end
            end
            // Outside an active frame the clock idles at the live polarity setting.
            if ((state_q != XFER) || (state_d == IDLE)) begin
                sclk_q <= cpol_i;
            end else if (tx_fire) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

    assign ss_o                 = (state_q == IDLE);
    assign tip_o                = (state_q != IDLE);
    assign sclk_o               = sclk_q;
    assign send_data_o          = (state_q == START);
    assign receive_data_o       = (state_q == DONE);
    assign spif_o               = (state_q == DONE);
    assign mosi_send_sclk_o     = tx_fire && !sclk_q;
    assign mosi_send_sclk0_o    = tx_fire && sclk_q;
    assign miso_receive_sclk_o  = rx_rise_q;
    assign miso_receive_sclk0_o = rx_fall_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - scoreboard bench for spi_xfer_ctrl
module tb_spi_xfer_ctrl;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       spe_i = 1'b1, cpol_i = 1'b0, cpha_i = 1'b0;
    logic [2:0] sppr_i = 3'd0, spr_i = 3'd0;
    logic       send_req_i = 1'b0, ss_in_i = 1'b1;
    logic       ss_o, sclk_o, send_data_o, receive_data_o;
    logic       mosi_send_sclk_o, mosi_send_sclk0_o;
    logic       miso_receive_sclk_o, miso_receive_sclk0_o;
    logic       tip_o, spif_o, modf_o;

    spi_xfer_ctrl dut (
        .PCLK                 (PCLK),
        .PRESETn              (PRESETn),
        .spe_i                (spe_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .sppr_i               (sppr_i),
        .spr_i                (spr_i),
        .send_req_i           (send_req_i),
        .ss_in_i              (ss_in_i),
        .ss_o                 (ss_o),
        .sclk_o               (sclk_o),
        .send_data_o          (send_data_o),
        .receive_data_o       (receive_data_o),
        .mosi_send_sclk_o     (mosi_send_sclk_o),
        .mosi_send_sclk0_o    (mosi_send_sclk0_o),
        .miso_receive_sclk_o  (miso_receive_sclk_o),
        .miso_receive_sclk0_o (miso_receive_sclk0_o),
        .tip_o                (tip_o),
        .spif_o               (spif_o),
        .modf_o               (modf_o)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Event kinds: 0 send_data, 1 mosi_send(rise), 2 mosi_send0(fall),
    // 3 miso_receive(rise), 4 miso_receive0(fall), 5 spif, 6 receive_data
    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  tmp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_en = 1'b1;
    int   tog = 0;
    logic sclk_prev = 1'b0;
    logic [6:0] mon_evs;
    ev_t  mon_e;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge PCLK) begin
        if (sclk_o !== sclk_prev) tog++;
        sclk_prev = sclk_o;
        mon_evs = {receive_data_o, spif_o, miso_receive_sclk0_o, miso_receive_sclk_o,
                   mosi_send_sclk0_o, mosi_send_sclk_o, send_data_o};
        if (sb_en) begin
            for (int k = 0; k < 7; k++) begin
                if (mon_evs[k]) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", k, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("event_kind", k, mon_e.kind);
                        chk("event_cycle", cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic add_ev(input int k, input int c);
        ev_t e;
        int  i;
        e.kind = k;
        e.cyc  = c;
        i = 0;
        while (i < tmp_q.size() && (tmp_q[i].cyc * 8 + tmp_q[i].kind) <= (c * 8 + k)) i++;
        tmp_q.insert(i, e);
    endtask

    // Expected strobes of a frame requested in cycle n with half-period h.
    task automatic push_frame(input int n, input int h, input bit cpol, input int nedges, input bit full);
        bit lev;
        tmp_q.delete();
        add_ev(0, n + 1);
        for (int k = 0; k < nedges; k++) begin
            lev = cpol ^ k[0];
            add_ev(lev ? 2 : 1, n + 1 + h + k * h);
            add_ev(lev ? 4 : 3, n + 2 + h + k * h);
        end
        if (full) begin
            add_ev(5, n + 3 + 16 * h);
            add_ev(6, n + 3 + 16 * h);
        end
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    endtask

    task automatic wait_to(input int c);
        int guard;
        guard = 0;
        while (cyc < c && guard < 100000) begin
            @(posedge PCLK);
            #1;
            guard++;
        end
    endtask

    task automatic sample_at(input int c);
        wait_to(c);
        @(negedge PCLK);
    endtask

    task automatic request(input int n);
        wait_to(n);
        send_req_i = 1'b1;
        wait_to(n + 1);
        send_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t0, h;

        // Reset state
        sample_at(1);
        chk("reset_ss", ss_o, 1);
        chk("reset_sclk", sclk_o, 0);
        chk("reset_tip", tip_o, 0);
        chk("reset_modf", modf_o, 0);
        chk("reset_send_data", send_data_o, 0);
        wait_to(3);
        PRESETn = 1'b1;

        // H=1, cpol=0
        n = 6;
        wait_to(n);
        push_frame(n, 1, 1'b0, 16, 1'b1);
        request(n);
        t0 = tog;
        sample_at(n + 2);
        chk("a_tip_xfer", tip_o, 1);
        chk("a_ss_xfer", ss_o, 0);
        sample_at(n + 3);
        chk("a_sclk_first", sclk_o, 1);
        sample_at(n + 19);
        chk("a_ss_done", ss_o, 0);
        wait_to(n + 20);
        chk("a_toggles", tog - t0, 16);
        sample_at(n + 20);
        chk("a_ss_idle", ss_o, 1);
        chk("a_tip_idle", tip_o, 0);
        chk("a_sclk_end", sclk_o, 0);
        sample_at(n + 22);
        chk("a_queue_empty", exp_q.size(), 0);

        // H=2, cpol=1, cpha=1
        wait_to(30);
        cpol_i = 1'b1; cpha_i = 1'b1; sppr_i = 3'd1; spr_i = 3'd0;
        sample_at(32);
        chk("b_idle_sclk", sclk_o, 1);
        n = 34;
        wait_to(n);
        push_frame(n, 2, 1'b1, 16, 1'b1);
        request(n);
        t0 = tog;
        sample_at(n + 35);
        chk("b_tip_done", tip_o, 1);
        wait_to(n + 36);
        chk("b_toggles", tog - t0, 16);
        sample_at(n + 36);
        chk("b_ss_idle", ss_o, 1);
        chk("b_sclk_end", sclk_o, 1);
        sample_at(n + 38);
        chk("b_queue_empty", exp_q.size(), 0);

        // H=2 frame with cpol/baud rewritten mid-frame
        wait_to(75);
        cpol_i = 1'b0; cpha_i = 1'b0; sppr_i = 3'd0; spr_i = 3'd1;
        n = 78;
        wait_to(n);
        push_frame(n, 2, 1'b0, 16, 1'b1);
        request(n);
        t0 = tog;
        wait_to(n + 10);
        cpol_i = 1'b1; sppr_i = 3'd7; spr_i = 3'd7;
        wait_to(n + 36);
        chk("c_toggles", tog - t0, 16);
        sample_at(n + 36);
        chk("c_ss_idle", ss_o, 1);
        chk("c_sclk_new_cpol", sclk_o, 1);
        sample_at(n + 38);
        chk("c_queue_empty", exp_q.size(), 0);

        // H=12 (sppr=2, spr=2), cpol=0
        wait_to(120);
        cpol_i = 1'b0; sppr_i = 3'd2; spr_i = 3'd2;
        h = 12;
        n = 123;
        wait_to(n);
        push_frame(n, h, 1'b0, 16, 1'b1);
        request(n);
        sample_at(n + 2 + h);
        chk("d_sclk_first", sclk_o, 1);
        sample_at(n + 4 + 16 * h);
        chk("d_ss_idle", ss_o, 1);
        sample_at(n + 6 + 16 * h);
        chk("d_queue_empty", exp_q.size(), 0);

        // spe low at 5th toggle, plus an ignored second request
        n = cyc + 3;
        sppr_i = 3'd1; spr_i = 3'd0;
        wait_to(n);
        push_frame(n, 2, 1'b0, 5, 1'b0);
        request(n);
        request(n + 6);
        wait_to(n + 12);
        spe_i = 1'b0;
        wait_to(n + 13);
        spe_i = 1'b1;
        sample_at(n + 13);
        chk("e_ss_abort", ss_o, 1);
        chk("e_tip_abort", tip_o, 0);
        sample_at(n + 40);
        chk("e_queue_empty", exp_q.size(), 0);

        // Mode fault
        n = cyc + 3;
        wait_to(n);
`ifdef SPI_MODF_EN
        push_frame(n, 2, 1'b0, 5, 1'b0);
        request(n);
        wait_to(n + 12);
        ss_in_i = 1'b0;
        wait_to(n + 13);
        ss_in_i = 1'b1;
        sample_at(n + 13);
        chk("f_ss_abort", ss_o, 1);
        chk("f_modf_set", modf_o, 1);
        sample_at(n + 16);
        chk("f_modf_sticky", modf_o, 1);
        wait_to(n + 17);
        spe_i = 1'b0;
        wait_to(n + 18);
        spe_i = 1'b1;
        sample_at(n + 18);
        chk("f_modf_clear", modf_o, 0);
`else
        push_frame(n, 2, 1'b0, 16, 1'b1);
        request(n);
        wait_to(n + 12);
        ss_in_i = 1'b0;
        wait_to(n + 13);
        ss_in_i = 1'b1;
        sample_at(n + 13);
        chk("f_tip_kept", tip_o, 1);
        chk("f_modf_zero", modf_o, 0);
        sample_at(n + 36);
        chk("f_ss_idle", ss_o, 1);
`endif
        sample_at(n + 40);
        chk("f_queue_empty", exp_q.size(), 0);

        // Asynchronous reset mid-XFER
        sb_en = 1'b0;
        sppr_i = 3'd0; spr_i = 3'd0;
        n = cyc + 3;
        request(n);
        wait_to(n + 9);
        chk("r_sclk_before", sclk_o, 1);
        PRESETn = 1'b0;
        #2;
        chk("r_ss_async", ss_o, 1);
        chk("r_sclk_async", sclk_o, 0);
        chk("r_tip_async", tip_o, 0);
        chk("r_mosi_async", mosi_send_sclk_o, 0);
        wait_to(n + 11);
        PRESETn = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        sample_at(n + 12);
        chk("r_ss_after", ss_o, 1);
        chk("r_tip_after", tip_o, 0);
        sample_at(n + 20);
        chk("r_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Transfer sequencer for the SPI master datapath. It generates the baud-rate serial clock, slave select, and the per-edge strobes consumed by `spi_sr`, and runs each 8-bit frame from start request to completion. It sits between the APB register slice, which supplies configuration and start requests, and `spi_sr` plus the SCLK/SS pads.

## Interface
- `BAUD_W`, 12, width of the baud half-period counter. Must hold 1024.
- `PCLK` in 1: system clock; all logic on rising edge.
- `PRESETn` in 1: asynchronous active-low reset.
- `spe_i` in 1: SPI enable; low aborts any transfer.
- `cpol_i`, `cpha_i` in 1 each: clock polarity and phase.
- `sppr_i` in 3: baud pre-selection.
- `spr_i` in 3: baud selection.
- `send_req_i` in 1: one-cycle start request (data register written).
- `ss_in_i` in 1: external SS pin, used by mode-fault detection only.
- `ss_o` out 1: slave select, active low.
- `sclk_o` out 1: serial clock, registered.
- `send_data_o` out 1: load pulse to the shift register.
- `receive_data_o` out 1: received byte valid pulse.
- `mosi_send_sclk_o`, `mosi_send_sclk0_o` out 1 each: pre-rising / pre-falling send strobes.
- `miso_receive_sclk_o`, `miso_receive_sclk0_o` out 1 each: post-rising / post-falling sample strobes.
- `tip_o` out 1: transfer in progress.
- `spif_o` out 1: transfer-complete pulse.
- `modf_o` out 1: mode fault, sticky until `spe_i` low.

## Operation
- Divisor D = (sppr+1)·2^(spr+1), range 2..2048. Half-period H = D/2, range 1..1024.
- `cpol`, `cpha`, `sppr`, `spr` are latched in START and held for the whole frame. Mid-frame register writes have no effect until the next frame.
- FSM states: IDLE, START, XFER, DONE.
  - IDLE → START: `send_req_i` && `spe_i`.
  - START → XFER: unconditional. `send_data_o`=1 for this cycle.
  - XFER → DONE: after the 16th receive strobe.
  - DONE → IDLE: unconditional. `receive_data_o`=1 and `spif_o`=1 for this cycle.
- In XFER, the baud counter counts 0..H-1 and wraps. At count H-1 a send strobe fires and `sclk_o` toggles on the next edge, unless 16 toggles are already done.
  - The send strobe is `mosi_send_sclk_o` if the coming toggle is rising, `mosi_send_sclk0_o` if falling.
- The cycle in which `sclk_o` shows its new level carries the matching receive strobe: `miso_receive_sclk_o` after rising, `miso_receive_sclk0_o` after falling.
- Edge counter runs 0..15. Exactly 16 sclk toggles per frame, 8 of each polarity. `sclk_o` ends at latched cpol.
- `ss_o`=0 and `tip_o`=1 in START, XFER and DONE. In IDLE, `ss_o`=1, `tip_o`=0, and `sclk_o` follows `cpol_i`.
- `send_req_i` outside IDLE is ignored.
- `spe_i` low in any state: next cycle is IDLE with `ss_o`=1, `sclk_o`=cpol, no `receive_data_o` and no `spif_o`.
- All strobes are single-cycle and mutually exclusive within their send/receive pair.

## Timing
- Reset values: `ss_o`=1, `sclk_o`=0, `tip_o`=0, `modf_o`=0, all pulses 0. State is IDLE and counters are 0.
- With request in cycle N:
  - START at N+1.
  - XFER spans N+2..N+2+16H.
  - DONE at N+3+16H.
  - IDLE at N+4+16H.
- First send strobe is at N+1+H and first toggle at N+2+H.
- `PRESETn` asserted mid-frame forces reset values immediately (asynchronous).

## Configuration
- `SPI_MODF_EN` defined: `ss_in_i` low while `spe_i`=1 and state ≠ IDLE forces IDLE next cycle and sets `modf_o`. `modf_o` clears when `spe_i`=0.
- `SPI_MODF_EN` undefined: `ss_in_i` is ignored and `modf_o` is tied 0.

## Structure
- Package `spi_pkg` holds:
  - the state enum (IDLE/START/XFER/DONE),
  - `BAUD_W` default,
  - frame constants: `SPI_FRAME_BITS`=8, `SPI_FRAME_EDGES`=16.
- Sub-module `spi_baud_gen` contains the divisor/half-period computation, the baud counter, and the terminal-count output. The FSM, edge counter, sclk register and strobe decode stay in `spi_xfer_ctrl`.

## Test plan
- Reset mid-XFER, `PRESETn`=0 → outputs at reset values in the same cycle. After release, IDLE with `ss_o`=1.
- sppr=0, spr=0, cpol=0, req at N → `send_data_o` at N+1, 16 toggles at N+3..N+18, `spif_o`/`receive_data_o` at N+19, `ss_o`=1 at N+20.
- sppr=1, spr=0, cpol=1, cpha=1 → H=2, sclk idles 1, first strobe `mosi_send_sclk0_o`, `spif_o` at N+35, 8 strobes of each type.
- `cpol_i` changed mid-frame → frame unaffected. After DONE, idle level follows the new `cpol_i`.
- `spe_i`=0 at 5th toggle → IDLE next cycle, `ss_o`=1, no `spif_o`. A second `send_req_i` during XFER is ignored.
- `SPI_MODF_EN` on, `ss_in_i`=0 during XFER → abort and `modf_o`=1 until `spe_i`=0. Macro off → transfer completes normally and `modf_o`=0.
